// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX FIFO sequencer, RX capture, baud register and status flags.
// Optional IRQEN register and registered interrupt are enabled by defining UART_MMIO_IRQ_EN.
module uart_mmio_ctrl #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned TX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        uart_we,
  output logic [7:0]  uart_data,
  output logic [31:0] uart_baud,
  output logic [31:0] uart_clk_freq,
  input  logic        uart_busy,
  input  logic        uart_read_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_out_valid,
  output logic        irq
);

  localparam int AW = $clog2(TX_DEPTH);

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_BAUD   = 3'd3;
  localparam logic [2:0] REG_IRQEN  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_t;

  typedef logic [AW:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  tx_state_t   state, state_nx;
  ptr_t        wr_ptr, rd_ptr;
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun, tx_overflow;
  logic        out_valid_q;
  logic [31:0] baud_q;
  logic [31:0] irqen_rdata;
  logic [31:0] rd_mux;

  logic [2:0]  reg_idx;
  logic        rd_hit, push_req, push, pop;
  logic        fifo_full, fifo_empty, rx_rise, baud_accept;
  logic        unused_addr_bits;

  assign reg_idx          = bus_addr[4:2];
  assign unused_addr_bits = ^bus_addr[1:0];

  // A simultaneous write wins; the read is dropped entirely.
  assign rd_hit   = bus_re && !bus_we;
  assign push_req = bus_we && (reg_idx == REG_TXDATA);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Fullness is judged before any same-cycle pop.
  assign push = push_req && !fifo_full;
  assign pop  = (state == S_ISSUE) && !uart_busy && uart_read_ready;

  assign rx_rise     = uart_out_valid && !out_valid_q;
  assign baud_accept = bus_we && (reg_idx == REG_BAUD) && fifo_empty &&
                       (state == S_IDLE) && (bus_wdata != 32'd0);

  assign uart_baud     = baud_q;
  assign uart_clk_freq = 32'(CLK_HZ);

  // NOTE: storage array has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    uart_we   = 1'b0;
    uart_data = 8'h00;
    case (state)
      S_IDLE:      if (!fifo_empty && !uart_busy && uart_read_ready) state_nx = S_ISSUE;
      S_ISSUE: begin
        uart_we   = 1'b1;
        uart_data = fifo_mem[rd_ptr[AW-1:0]];
        state_nx  = pop ? S_WAIT_BUSY : S_IDLE;
      end
      S_WAIT_BUSY: if (uart_busy)  state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (!uart_busy) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx)
      REG_RXDATA: rd_mux = {24'd0, rx_byte};
      REG_STATUS: rd_mux = {26'd0, uart_busy, tx_overflow, rx_overrun,
                            rx_valid, fifo_empty, fifo_full};
      REG_BAUD:   rd_mux = baud_q;
      REG_IRQEN:  rd_mux = irqen_rdata;
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      out_valid_q <= 1'b0;
      baud_q      <= 32'(DEFAULT_BAUD);
      bus_rdata   <= 32'd0;
      bus_rvalid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      out_valid_q <= uart_out_valid;

      // Clears from software reads come first so a same-cycle hardware set wins.
      if (rd_hit && (reg_idx == REG_STATUS)) begin
        rx_overrun  <= 1'b0;
        tx_overflow <= 1'b0;
      end
      if (rd_hit && (reg_idx == REG_RXDATA)) rx_valid <= 1'b0;
      if (push_req && fifo_full) tx_overflow <= 1'b1;
      if (rx_rise) begin
        rx_byte  <= uart_rx_data;
        rx_valid <= 1'b1;
        if (rx_valid) rx_overrun <= 1'b1;
      end

      if (baud_accept) baud_q <= bus_wdata;

      bus_rvalid <= rd_hit;
      if (rd_hit) bus_rdata <= rd_mux;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic [1:0] irq_en;
  logic       irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (bus_we && (reg_idx == REG_IRQEN)) irq_en <= bus_wdata[1:0];
      irq_q <= (irq_en[0] & rx_valid) | (irq_en[1] & fifo_empty & (state == S_IDLE));
    end
  end

  assign irq         = irq_q;
  assign irqen_rdata = {30'd0, irq_en};
`else
  assign irq         = 1'b0;
  assign irqen_rdata = 32'd0;
`endif

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl; the bench plays the UART core by hand.
// Define UART_MMIO_IRQ_EN for both files to exercise the interrupt build.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        uart_we;
  logic [7:0]  uart_data;
  logic [31:0] uart_baud;
  logic [31:0] uart_clk_freq;
  logic        uart_busy = 1'b0;
  logic        uart_read_ready = 1'b1;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_out_valid = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  uart_mmio_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_re         (bus_re),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_rvalid     (bus_rvalid),
    .uart_we        (uart_we),
    .uart_data      (uart_data),
    .uart_baud      (uart_baud),
    .uart_clk_freq  (uart_clk_freq),
    .uart_busy      (uart_busy),
    .uart_read_ready(uart_read_ready),
    .uart_rx_data   (uart_rx_data),
    .uart_out_valid (uart_out_valid),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  // Returns a sentinel when bus_rvalid does not pulse, so data compares fail.
  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rvalid ? bus_rdata : 32'hDEAD_BEEF;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b; uart_out_valid = 1'b1;
    @(negedge clk);
    uart_out_valid = 1'b0;
  endtask

  // Waits (bounded) for a write_enable pulse, then acts as a core busy for 3 cycles.
  task automatic core_accept(output logic [7:0] d, output logic seen, output logic single);
    seen = 1'b0; single = 1'b0; d = 8'h00;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (uart_we) begin seen = 1'b1; d = uart_data; end
    end
    if (seen) begin
      @(negedge clk);
      single = !uart_we;
      uart_busy = 1'b1;
      repeat (3) @(negedge clk);
      uart_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    n_checks++; if (uart_we !== 1'b0) $display("FAIL reset_uart_we: got %b exp 0", uart_we); else n_pass++;
    n_checks++; if (uart_data !== 8'h00) $display("FAIL reset_uart_data: got %h exp 00", uart_data); else n_pass++;
    n_checks++; if (uart_baud !== 32'd115200) $display("FAIL reset_baud: got %0d exp 115200", uart_baud); else n_pass++;
    n_checks++; if (uart_clk_freq !== 32'd50_000_000) $display("FAIL reset_clk_freq: got %0d exp 50000000", uart_clk_freq); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq); else n_pass++;
    n_checks++; if (bus_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b exp 0", bus_rvalid); else n_pass++;
    n_checks++; if (bus_rdata !== 32'd0) $display("FAIL reset_rdata: got %h exp 0", bus_rdata); else n_pass++;
    rst = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL reset_status: got %h exp 00000002", r); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h00) $display("FAIL reset_rxdata: got %h exp 00000000", r); else n_pass++;
  endtask

  task automatic test_tx_single();
    logic [31:0] r;
    bus_write(5'h00, 32'h41);
    n_checks++; if (uart_we !== 1'b0) $display("FAIL tx_latency_early: got %b exp 0", uart_we); else n_pass++;
    @(negedge clk);
    n_checks++; if (uart_we !== 1'b1) $display("FAIL tx_issue_we: got %b exp 1", uart_we); else n_pass++;
    n_checks++; if (uart_data !== 8'h41) $display("FAIL tx_issue_data: got %h exp 41", uart_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (uart_we !== 1'b0) $display("FAIL tx_we_one_cycle: got %b exp 0", uart_we); else n_pass++;
    uart_busy = 1'b1;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h22) $display("FAIL tx_status_busy: got %h exp 00000022", r); else n_pass++;
    uart_busy = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL tx_status_done: got %h exp 00000002", r); else n_pass++;
  endtask

  task automatic test_tx_retry();
    logic [31:0] r;
    logic [7:0]  d;
    logic        seen, single;
    bus_write(5'h00, 32'h77);
    @(negedge clk);
    n_checks++; if (uart_we !== 1'b1) $display("FAIL retry_issue: got %b exp 1", uart_we); else n_pass++;
    uart_read_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (uart_we !== 1'b0) $display("FAIL retry_backoff: got %b exp 0", uart_we); else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h00) $display("FAIL retry_not_popped: got %h exp 00000000", r); else n_pass++;
    uart_read_ready = 1'b1;
    core_accept(d, seen, single);
    n_checks++; if (!seen || d !== 8'h77) $display("FAIL retry_resend: got %h seen %b exp 77", d, seen); else n_pass++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    logic [7:0]  d;
    logic        seen, single;
    int          extra;
    repeat (2) @(negedge clk);
    uart_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_addr = 5'h00; bus_wdata = 32'(i); bus_we = 1'b1;
    end
    @(negedge clk);
    bus_we = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h31) $display("FAIL ovf_status_first: got %h exp 00000031", r); else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h21) $display("FAIL ovf_status_cleared: got %h exp 00000021", r); else n_pass++;
    uart_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      core_accept(d, seen, single);
      n_checks++;
      if (!seen || !single || d !== 8'(i))
        $display("FAIL ovf_drain_%0d: got %h seen %b single %b exp %h", i, d, seen, single, 8'(i));
      else n_pass++;
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_we) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL ovf_no_extra_tx: got %0d exp 0", extra); else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL ovf_status_empty: got %h exp 00000002", r); else n_pass++;
  endtask

  task automatic test_rx();
    logic [31:0] r;
    pulse_rx(8'h5A);
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h06) $display("FAIL rx_status_valid: got %h exp 00000006", r); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h5A) $display("FAIL rx_data: got %h exp 0000005a", r); else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL rx_status_cleared: got %h exp 00000002", r); else n_pass++;
    // A held-high outValid must not re-capture.
    @(negedge clk);
    uart_rx_data = 8'h11; uart_out_valid = 1'b1;
    repeat (3) @(negedge clk);
    uart_rx_data = 8'hEE;
    @(negedge clk);
    uart_out_valid = 1'b0;
    pulse_rx(8'h22);
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h0E) $display("FAIL rx_overrun_status: got %h exp 0000000e", r); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h22) $display("FAIL rx_overrun_data: got %h exp 00000022", r); else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL rx_overrun_cleared: got %h exp 00000002", r); else n_pass++;
  endtask

  task automatic test_rx_read_collision();
    logic [31:0] r;
    pulse_rx(8'h33);
    @(negedge clk);
    bus_addr = 5'h04; bus_re = 1'b1; uart_rx_data = 8'h44; uart_out_valid = 1'b1;
    @(negedge clk);
    bus_re = 1'b0; uart_out_valid = 1'b0;
    n_checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h33)
      $display("FAIL collide_read: got %h rvalid %b exp 00000033", bus_rdata, bus_rvalid);
    else n_pass++;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h0E) $display("FAIL collide_status: got %h exp 0000000e", r); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h44) $display("FAIL collide_data: got %h exp 00000044", r); else n_pass++;
  endtask

  task automatic test_baud();
    logic [31:0] r;
    logic [7:0]  d;
    logic        seen, single;
    uart_read_ready = 1'b0;
    bus_write(5'h00, 32'h55);
    bus_write(5'h0C, 32'd9600);
    n_checks++; if (uart_baud !== 32'd115200) $display("FAIL baud_busy_port: got %0d exp 115200", uart_baud); else n_pass++;
    bus_read(5'h0C, r);
    n_checks++; if (r !== 32'd115200) $display("FAIL baud_busy_reg: got %0d exp 115200", r); else n_pass++;
    uart_read_ready = 1'b1;
    core_accept(d, seen, single);
    n_checks++; if (!seen || d !== 8'h55) $display("FAIL baud_drain: got %h seen %b exp 55", d, seen); else n_pass++;
    bus_write(5'h0C, 32'd9600);
    n_checks++; if (uart_baud !== 32'd9600) $display("FAIL baud_idle_port: got %0d exp 9600", uart_baud); else n_pass++;
    bus_read(5'h0C, r);
    n_checks++; if (r !== 32'd9600) $display("FAIL baud_idle_reg: got %0d exp 9600", r); else n_pass++;
    bus_write(5'h0C, 32'd0);
    n_checks++; if (uart_baud !== 32'd9600) $display("FAIL baud_zero: got %0d exp 9600", uart_baud); else n_pass++;
  endtask

  task automatic test_we_re_same_cycle();
    logic [31:0] r;
    @(negedge clk);
    bus_addr = 5'h0C; bus_wdata = 32'd19200; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    n_checks++; if (bus_rvalid !== 1'b0) $display("FAIL wr_rd_rvalid: got %b exp 0", bus_rvalid); else n_pass++;
    n_checks++; if (uart_baud !== 32'd19200) $display("FAIL wr_rd_write: got %0d exp 19200", uart_baud); else n_pass++;
    bus_read(5'h14, r);
    n_checks++; if (r !== 32'd0) $display("FAIL unmapped_read: got %h exp 00000000", r); else n_pass++;
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'd0) $display("FAIL txdata_read: got %h exp 00000000", r); else n_pass++;
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] r;
    logic        seen;
    int          extra;
    uart_busy = 1'b1;
    for (int i = 0; i < 4; i++) bus_write(5'h00, 32'hA0 + 32'(i));
    pulse_rx(8'h99);
    uart_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (uart_we) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL mid_issue: got no uart_we exp pulse"); else n_pass++;
    @(negedge clk);
    uart_busy = 1'b1;
    @(negedge clk);
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h24) $display("FAIL mid_status: got %h exp 00000024", r); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (uart_we !== 1'b0) $display("FAIL mid_rst_we: got %b exp 0", uart_we); else n_pass++;
    n_checks++; if (bus_rdata !== 32'd0) $display("FAIL mid_rst_rdata: got %h exp 0", bus_rdata); else n_pass++;
    n_checks++; if (uart_baud !== 32'd115200) $display("FAIL mid_rst_baud: got %0d exp 115200", uart_baud); else n_pass++;
    rst = 1'b0; uart_busy = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'h02) $display("FAIL mid_rst_status: got %h exp 00000002", r); else n_pass++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_we) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL mid_rst_flushed: got %0d exp 0", extra); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] r;
`ifdef UART_MMIO_IRQ_EN
    bus_write(5'h10, 32'h1);
    bus_read(5'h10, r);
    n_checks++; if (r !== 32'h1) $display("FAIL irqen_read: got %h exp 00000001", r); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b exp 0", irq); else n_pass++;
    pulse_rx(8'h5C);
    repeat (2) @(negedge clk);
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_rx_set: got %b exp 1", irq); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h5C) $display("FAIL irq_rxdata: got %h exp 0000005c", r); else n_pass++;
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_clear: got %b exp 0", irq); else n_pass++;
`else
    bus_write(5'h10, 32'h3);
    bus_read(5'h10, r);
    n_checks++; if (r !== 32'h0) $display("FAIL irqen_absent: got %h exp 00000000", r); else n_pass++;
    pulse_rx(8'h5C);
    repeat (2) @(negedge clk);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_tied: got %b exp 0", irq); else n_pass++;
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h5C) $display("FAIL irq_rxdata: got %h exp 0000005c", r); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_retry();
    test_tx_overflow();
    test_rx();
    test_rx_read_collision();
    test_baud();
    test_we_re_same_cycle();
    test_reset_mid_transfer();
    test_irq();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sits between the CPU load/store path and the `Uart` core. It buffers outgoing bytes in a TX FIFO and sequences them into the core one at a time using the core's `busy`/`read_ready` handshake. It captures received bytes on the rising edge of the core's `outValid`, holds the baud-rate configuration register, and exposes status and sticky error flags to software.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency, driven constant on `uart_clk_freq`
- `DEFAULT_BAUD`, 115200: reset value of the BAUD register
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1: clock
- `rst`  in  1: reset, synchronous, active-high
- `bus_addr`  in  5: byte address, bits [1:0] ignored
- `bus_we`  in  1: write strobe, one cycle
- `bus_re`  in  1: read strobe, one cycle
- `bus_wdata`  in  32: write data
- `bus_rdata`  out  32: registered read data
- `bus_rvalid`  out  1: read data valid, one-cycle pulse
- `uart_we`  out  1: to core `write_enable`
- `uart_data`  out  8: to core `data`
- `uart_baud`  out  32: to core `baud_rate`
- `uart_clk_freq`  out  32: to core `clk_frequency`
- `uart_busy`  in  1: from core `busy`
- `uart_read_ready`  in  1: from core `read_ready`
- `uart_rx_data`  in  8: from core `rx_data`
- `uart_out_valid`  in  1: from core `outValid`
- `irq`  out  1: level interrupt

## Operation
Register map:
- 0x00 TXDATA (W): push `bus_wdata[7:0]`. If the FIFO is full, the byte is dropped and `tx_overflow` is set. Reads return 0.
- 0x04 RXDATA (R): `{24'b0, rx_byte}`; the read clears `rx_valid`.
- 0x08 STATUS (R): bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_valid`, bit3 `rx_overrun`, bit4 `tx_overflow`, bit5 `uart_busy`. A read returns the current values, then clears bits 3 and 4.
- 0x0C BAUD (RW): written only when the FIFO is empty and the TX FSM is in IDLE. Otherwise, or when the value is 0, the write is ignored.
- 0x10 IRQEN (RW, see Configuration): bit0 rx, bit1 tx_empty.
- Unmapped addresses: reads return 0, writes are ignored.

TX FSM:
- IDLE → ISSUE when the FIFO is non-empty, `!uart_busy` and `uart_read_ready`.
- ISSUE: `uart_we`=1 for exactly one cycle with `uart_data` = FIFO head.
  - If `!uart_busy && uart_read_ready` in that cycle: pop, go to WAIT_BUSY.
  - Else: no pop, go back to IDLE to retry.
- WAIT_BUSY → WAIT_DONE when `uart_busy`=1.
- WAIT_DONE → IDLE when `uart_busy`=0.

RX path:
- Rising edge of `uart_out_valid` (registered previous value 0, current 1) latches `rx_byte` ← `uart_rx_data` and sets `rx_valid`.
- If `rx_valid` is already set on capture: set `rx_overrun` and overwrite `rx_byte`.

Boundary rules:
- Push and pop in the same cycle: fullness is evaluated before the pop, so a push to a full FIFO is dropped even if a pop happens that cycle.
- RXDATA read in the same cycle as a capture: the capture wins and `rx_valid` stays 1.
- `bus_we` and `bus_re` in the same cycle: the write is performed, the read is ignored, and there is no `bus_rvalid`.
- FIFO pointers are `log2(TX_DEPTH)+1` bits wide; the MSB distinguishes full from empty, and pointers wrap modulo 2·`TX_DEPTH`.
- `rst` mid-transfer: the FIFO is flushed, the FSM returns to IDLE, and all flags clear. The core is reset by the same `rst`.

## Timing
- Reset values: `bus_rdata`=0, `bus_rvalid`=0, `uart_we`=0, `uart_data`=0, `uart_baud`=`DEFAULT_BAUD`, `uart_clk_freq`=`CLK_HZ`, `irq`=0. The FIFO is empty and `rx_byte`=0.
- Read latency: `bus_re` at cycle N → `bus_rdata`/`bus_rvalid` valid at N+1.
- Write effect: visible in registers at N+1.
- Minimum time from a TXDATA write into an empty FIFO with an idle core to `uart_we`: 2 cycles (push at N+1, ISSUE at N+2).
- Back-to-back bytes: the next ISSUE comes no earlier than 1 cycle after `uart_busy` falls.
- `uart_baud` updates the cycle after an accepted BAUD write.

## Configuration
- `UART_MMIO_IRQ_EN` defined:
  - IRQEN register is implemented, reset value 0.
  - `irq` is registered: `irq` = (IRQEN[0] & `rx_valid`) | (IRQEN[1] & `tx_empty` & FSM IDLE).
- Not defined:
  - The `irq` port still exists and is tied to 0.
  - 0x10 reads 0 and ignores writes.

## Test plan
- Write 0x41 to TXDATA with the core idle → `uart_we` pulses one cycle with `uart_data`=0x41; STATUS reads `tx_empty`=1 after `uart_busy` falls.
- Write 10 bytes (0x00–0x09) back-to-back with `TX_DEPTH`=8 and the core busy → the first 8 are queued, 2 are dropped, STATUS bit4=1 and it reads 0 on the second STATUS read. The core then receives 0x00–0x07 in order.
- Drive `uart_out_valid` rising with `uart_rx_data`=0x5A → STATUS bit2=1, RXDATA reads 0x5A, then STATUS bit2=0.
- Two captures (0x11, 0x22) without a read → RXDATA=0x22, STATUS bit3=1.
- Write BAUD=9600 while the FIFO is non-empty → ignored, BAUD reads 115200. Write 9600 when idle → `uart_baud`=9600. Write 0 → ignored.
- Assert `rst` during WAIT_DONE with 3 bytes queued → the next cycle has `uart_we`=0, `tx_empty`=1 and `bus_rdata`=0. With `UART_MMIO_IRQ_EN`, IRQEN=1 and an rx capture → `irq`=1 until RXDATA is read.
